// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one registered ALU stage among N_REQ requesters
// One transaction in flight: grant, issue, wait (with watchdog), respond.
module alu_rr_sched #(
   parameter int WIDTH   = 4,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15,
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int TW = $clog2(TIMEOUT + 1)
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   input  logic [N_REQ-1:0]       i_REQ_VALID,
   output logic [N_REQ-1:0]       o_REQ_READY,
   input  logic [N_REQ*WIDTH-1:0] i_REQ_A,
   input  logic [N_REQ*WIDTH-1:0] i_REQ_B,
   input  logic [N_REQ*2-1:0]     i_REQ_SEL,
   output logic [N_REQ-1:0]       o_RSP_VALID,
   input  logic [N_REQ-1:0]       i_RSP_READY,
   output logic [WIDTH-1:0]       o_RSP_Y,
   output logic                   o_RSP_ERR,
   output logic                   o_ALU_VALID,
   input  logic                   i_ALU_READY,
   output logic [WIDTH-1:0]       o_ALU_A,
   output logic [WIDTH-1:0]       o_ALU_B,
   output logic [1:0]             o_ALU_SEL,
   input  logic                   i_ALU_VALID,
   output logic                   o_ALU_READY,
   input  logic [WIDTH-1:0]       i_ALU_Y,
   output logic                   o_BUSY,
   output logic [IW-1:0]          o_GRANT_ID
);
   typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, RESP = 2'b11} state_t;
   state_t           state, state_d;
   logic [IW-1:0]    ptr, gnt, gnt_id;
   logic             found, expired;
   logic [TW-1:0]    timer;
   logic [WIDTH-1:0] a_q, b_q, y_q;
   logic [1:0]       sel_q;
   logic             err_q;
   // Scan offsets high to low so the nearest valid requester after ptr wins.
   always_comb begin
      found = 1'b0;
      gnt   = ptr;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (i_REQ_VALID[IW'((int'(ptr) + i) % N_REQ)]) begin
            found = 1'b1;
            gnt   = IW'((int'(ptr) + i) % N_REQ);
         end
   end
   assign expired = timer == TW'(TIMEOUT - 1);
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = found ? ISSUE : IDLE;
         ISSUE:   state_d = i_ALU_READY ? WAIT : ISSUE;
         WAIT:    state_d = (i_ALU_VALID || expired) ? RESP : WAIT;
         RESP:    state_d = i_RSP_READY[gnt_id] ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST)
         state <= IDLE;
      else
         state <= state_d;
   end
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         ptr    <= '0;
         gnt_id <= '0;
         timer  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sel_q  <= '0;
         y_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == IDLE && found) begin
            a_q    <= i_REQ_A[gnt*WIDTH +: WIDTH];
            b_q    <= i_REQ_B[gnt*WIDTH +: WIDTH];
            sel_q  <= i_REQ_SEL[gnt*2 +: 2];
            gnt_id <= gnt;
            ptr    <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
         end
         if (state == ISSUE && i_ALU_READY)
            timer <= '0;
         // A result on the final WAIT cycle beats the watchdog.
         if (state == WAIT) begin
            if (i_ALU_VALID) begin
               y_q   <= i_ALU_Y;
               err_q <= 1'b0;
            end else if (expired) begin
               y_q   <= '0;
               err_q <= 1'b1;
            end else
               timer <= timer + 1'b1;
         end
      end
   end
   assign o_REQ_READY = (state == IDLE && found) ? N_REQ'(1) << gnt : '0;
   assign o_RSP_VALID = (state == RESP) ? N_REQ'(1) << gnt_id : '0;
   assign o_RSP_Y     = y_q;
   assign o_RSP_ERR   = err_q;
   assign o_ALU_VALID = state == ISSUE;
   assign o_ALU_READY = state != RESP;
   assign o_ALU_A     = a_q;
   assign o_ALU_B     = b_q;
   assign o_ALU_SEL   = sel_q;
   assign o_BUSY      = state != IDLE;
   assign o_GRANT_ID  = gnt_id;
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: directed scoreboard bench for alu_rr_sched with a 1-cycle registered ALU model
// ALU ops: 00 add, 01 sub, 10 and, 11 xor (all mod 16).
module tb_alu_rr_sched;
   logic        i_CLK = 1'b0;
   logic        i_RST = 1'b1;
   logic [3:0]  i_REQ_VALID = '0;
   logic [3:0]  o_REQ_READY;
   logic [15:0] i_REQ_A = '0;
   logic [15:0] i_REQ_B = '0;
   logic [7:0]  i_REQ_SEL = '0;
   logic [3:0]  o_RSP_VALID;
   logic [3:0]  i_RSP_READY = 4'hF;
   logic [3:0]  o_RSP_Y;
   logic        o_RSP_ERR;
   logic        o_ALU_VALID;
   logic        i_ALU_READY = 1'b1;
   logic [3:0]  o_ALU_A, o_ALU_B;
   logic [1:0]  o_ALU_SEL;
   logic        i_ALU_VALID;
   logic        o_ALU_READY;
   logic [3:0]  i_ALU_Y;
   logic        o_BUSY;
   logic [1:0]  o_GRANT_ID;

   alu_rr_sched #(.WIDTH(4), .N_REQ(4), .TIMEOUT(15)) dut (
      .i_CLK(i_CLK), .i_RST(i_RST),
      .i_REQ_VALID(i_REQ_VALID), .o_REQ_READY(o_REQ_READY),
      .i_REQ_A(i_REQ_A), .i_REQ_B(i_REQ_B), .i_REQ_SEL(i_REQ_SEL),
      .o_RSP_VALID(o_RSP_VALID), .i_RSP_READY(i_RSP_READY),
      .o_RSP_Y(o_RSP_Y), .o_RSP_ERR(o_RSP_ERR),
      .o_ALU_VALID(o_ALU_VALID), .i_ALU_READY(i_ALU_READY),
      .o_ALU_A(o_ALU_A), .o_ALU_B(o_ALU_B), .o_ALU_SEL(o_ALU_SEL),
      .i_ALU_VALID(i_ALU_VALID), .o_ALU_READY(o_ALU_READY), .i_ALU_Y(i_ALU_Y),
      .o_BUSY(o_BUSY), .o_GRANT_ID(o_GRANT_ID)
   );

   always #5 i_CLK = ~i_CLK;

   int cyc = 0;
   always @(posedge i_CLK) cyc <= cyc + 1;

   // ALU stage model; mute suppresses results, late_v injects a stray result.
   logic       alu_v, alu_mute = 1'b0, late_v = 1'b0;
   logic [3:0] alu_y, late_y = '0;
   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      return (s == 2'd0) ? a + b : (s == 2'd1) ? a - b : (s == 2'd2) ? a & b : a ^ b;
   endfunction
   always @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         alu_v <= 1'b0;
         alu_y <= '0;
      end else begin
         alu_v <= o_ALU_VALID && i_ALU_READY && !alu_mute;
         alu_y <= alu_f(o_ALU_A, o_ALU_B, o_ALU_SEL);
      end
   end
   assign i_ALU_VALID = alu_v | late_v;
   assign i_ALU_Y     = late_v ? late_y : alu_y;

   typedef struct {int id; int y; int err; int lat;} exp_t;
   exp_t exp_q[$];
   int   gnt_q[$];
   int   checks = 0, errors = 0;
   int   rst_req = 0, rst_seen = 0;
   bit   fin_req = 1'b0, fin_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // Monitor: samples 2 time units before each rising edge.
   initial begin
      bit         stall_p = 1'b0, rsp_seen = 1'b0;
      logic [9:0] stall_v = '0;
      int         gnt_cyc = 0, rsp_cyc = 0;
      exp_t       e;
      forever begin
         @(negedge i_CLK);
         #3;
         if (rst_req != rst_seen) begin
            rst_seen = rst_req;
            chk("rst_alu_ready", {31'd0, o_ALU_READY}, 32'd1);
            chk("rst_outputs", {5'd0, o_REQ_READY, o_RSP_VALID, o_ALU_VALID, o_BUSY, o_GRANT_ID,
                                o_RSP_Y, o_RSP_ERR, o_ALU_A, o_ALU_B, o_ALU_SEL}, 32'd0);
         end
         if (i_RST) begin
            stall_p  = 1'b0;
            rsp_seen = 1'b0;
         end else begin
            if (stall_p)
               chk("stall_hold", {21'd0, o_ALU_VALID, o_ALU_A, o_ALU_B, o_ALU_SEL}, {21'd0, 1'b1, stall_v});
            stall_p = o_ALU_VALID && !i_ALU_READY;
            stall_v = {o_ALU_A, o_ALU_B, o_ALU_SEL};
            if (|o_REQ_READY) begin
               chk("req_ready_onehot", {31'd0, $onehot(o_REQ_READY)}, 32'd1);
               if (gnt_q.size() == 0)
                  chk("unexpected_grant", {28'd0, o_REQ_READY}, 32'd0);
               else
                  chk("grant_id", oh_idx(o_REQ_READY), gnt_q.pop_front());
               gnt_cyc = cyc;
            end
            if (|o_RSP_VALID) begin
               if (!rsp_seen) begin
                  rsp_seen = 1'b1;
                  rsp_cyc  = cyc;
               end
               if ((o_RSP_VALID & i_RSP_READY) != 4'd0) begin
                  rsp_seen = 1'b0;
                  chk("rsp_valid_onehot", {31'd0, $onehot(o_RSP_VALID)}, 32'd1);
                  if (exp_q.size() == 0)
                     chk("unexpected_rsp", {28'd0, o_RSP_VALID}, 32'd0);
                  else begin
                     e = exp_q.pop_front();
                     chk("rsp_id", oh_idx(o_RSP_VALID), e.id);
                     chk("rsp_y", {28'd0, o_RSP_Y}, e.y);
                     chk("rsp_err", {31'd0, o_RSP_ERR}, e.err);
                     chk("rsp_latency", rsp_cyc - gnt_cyc, e.lat);
                  end
               end
            end
         end
         if (fin_req && !fin_ack) begin
            chk("rsp_queue_drained", exp_q.size(), 32'd0);
            chk("grant_queue_drained", gnt_q.size(), 32'd0);
            fin_ack = 1'b1;
         end
      end
   end

   task automatic set_op(input int k, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      i_REQ_A[k*4 +: 4]   = a;
      i_REQ_B[k*4 +: 4]   = b;
      i_REQ_SEL[k*2 +: 2] = s;
   endtask

   task automatic expect_rsp(input int id, input int y, input int err, input int lat);
      exp_t e;
      e = '{id, y, err, lat};
      gnt_q.push_back(id);
      exp_q.push_back(e);
   endtask

   // Called on a falling edge; returns just after the rising edge of the last grant.
   task automatic drive(input logic [3:0] mask, input bit hold, input int n);
      int         got = 0;
      logic [3:0] gm;
      i_REQ_VALID = mask;
      for (int t = 0; t < 300 && got < n; t++) begin
         #1;
         if (|o_REQ_READY) begin
            gm = o_REQ_READY;
            got++;
            @(posedge i_CLK);
            #1;
            if (!hold) i_REQ_VALID = i_REQ_VALID & ~gm;
            if (got == n) break;
         end
         @(negedge i_CLK);
      end
      i_REQ_VALID = '0;
      if (got < n) begin
         $display("FAIL grant_timeout got=%0d required=%0d", got, n);
         $fatal(1, "grant wait expired");
      end
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 300; t++) begin
         @(negedge i_CLK);
         #2;
         if (!o_BUSY) return;
      end
      $display("FAIL idle_timeout busy=%0d required=0", o_BUSY);
      $fatal(1, "idle wait expired");
   endtask

   initial begin
      @(negedge i_CLK);
      rst_req = 1;
      @(negedge i_CLK);
      i_RST = 1'b0;
      // T1: single request; other requesters' ready bits must not end RESP
      @(negedge i_CLK);
      set_op(0, 4'd3, 4'd4, 2'd0);
      expect_rsp(0, 7, 0, 3);
      i_RSP_READY = 4'b1110;
      drive(4'b0001, 1'b0, 1);
      repeat (6) @(negedge i_CLK);
      i_RSP_READY = 4'hF;
      wait_idle();
      // T4: ALU back-pressure for 5 cycles
      @(negedge i_CLK);
      set_op(1, 4'd5, 4'd3, 2'd1);
      expect_rsp(1, 2, 0, 8);
      i_ALU_READY = 1'b0;
      drive(4'b0010, 1'b0, 1);
      repeat (6) @(negedge i_CLK);
      i_ALU_READY = 1'b1;
      wait_idle();
      // T3: ptr moves to 3, then 0101 grants 0 and then 2
      @(negedge i_CLK);
      set_op(2, 4'd6, 4'd3, 2'd2);
      expect_rsp(2, 2, 0, 3);
      drive(4'b0100, 1'b0, 1);
      wait_idle();
      @(negedge i_CLK);
      set_op(0, 4'd9, 4'd5, 2'd3);
      set_op(2, 4'd15, 4'd2, 2'd0);
      expect_rsp(0, 12, 0, 3);
      expect_rsp(2, 1, 0, 3);
      drive(4'b0101, 1'b0, 2);
      wait_idle();
      // T5: watchdog abort after 15 WAIT cycles, then a stray late result
      @(negedge i_CLK);
      set_op(3, 4'd1, 4'd1, 2'd0);
      expect_rsp(3, 0, 1, 17);
      alu_mute = 1'b1;
      drive(4'b1000, 1'b0, 1);
      wait_idle();
      alu_mute = 1'b0;
      @(negedge i_CLK);
      late_y = 4'd9;
      late_v = 1'b1;
      @(negedge i_CLK);
      late_v = 1'b0;
      set_op(1, 4'd8, 4'd1, 2'd1);
      expect_rsp(1, 7, 0, 3);
      drive(4'b0010, 1'b0, 1);
      wait_idle();
      // T6: reset while in WAIT drops the transaction
      @(negedge i_CLK);
      set_op(2, 4'd2, 4'd2, 2'd0);
      gnt_q.push_back(2);
      alu_mute = 1'b1;
      drive(4'b0100, 1'b0, 1);
      repeat (2) @(negedge i_CLK);
      #1;
      i_RST = 1'b1;
      rst_req++;
      @(negedge i_CLK);
      i_RST = 1'b0;
      alu_mute = 1'b0;
      wait_idle();
      // T2: all four valid from ptr=0 -> 0,1,2,3,0
      @(negedge i_CLK);
      set_op(0, 4'd1, 4'd2, 2'd0);
      set_op(1, 4'd2, 4'd2, 2'd1);
      set_op(2, 4'd3, 4'd2, 2'd2);
      set_op(3, 4'd4, 4'd2, 2'd3);
      expect_rsp(0, 3, 0, 3);
      expect_rsp(1, 0, 0, 3);
      expect_rsp(2, 2, 0, 3);
      expect_rsp(3, 6, 0, 3);
      expect_rsp(0, 3, 0, 3);
      drive(4'b1111, 1'b1, 5);
      wait_idle();
      repeat (3) @(negedge i_CLK);
      fin_req = 1'b1;
      for (int t = 0; t < 10 && !fin_ack; t++) @(negedge i_CLK);
      #5;
      if (!fin_ack) begin
         $display("FAIL final_check_timeout ack=0 required=1");
         $fatal(1, "final check not reached");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
